pc_unit: RTL and testbench

Parametrised program-counter unit for the pipeline's instruction-fetch stage, replacing the single fixed-width PC register. It holds the fetch address and advances it by a configurable increment. It also handles exception vectoring, branch/jump redirects, stall-deferred redirects and call/return prediction through a small circular return-address stack (RAS). It sits between the hazard/branch logic and the instruction memory address port.

---
 rtl/pc_pkg.sv | 19 +
 rtl/ras_stack.sv | 53 +++++
 rtl/pc_unit.sv | 132 +++++++++++++
 tb/tb_pc_unit.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage program-counter unit: FSM state and
// the next-PC source selected by the priority mux.
package pc_pkg;

   typedef enum logic {
      IDLE,
      RUN
   } pc_state_t;

   typedef enum logic [2:0] {
      EXC,
      HOLD,
      REDIR,
      PEND,
      RET,
      SEQ
   } pc_src_t;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a push when full silently overwrites the
// oldest entry, while the count saturates at DEPTH.
module ras_stack #(
   parameter int W     = 32,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] top_o,
   output logic         empty_o,
   output logic         full_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [W-1:0]     r_mem [DEPTH];
   logic [PTR_W-1:0] r_head;
   logic [CNT_W-1:0] r_count;
   logic [PTR_W-1:0] w_head_inc;
   logic             w_empty;
   logic             w_full;

   assign w_head_inc = r_head + PTR_W'(1);
   assign w_empty    = (r_count == '0);
   assign w_full     = (r_count == CNT_W'(DEPTH));

   // r_head always points at the most recent entry, so top is a plain read.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_head  <= '0;
         r_count <= '0;
      end else if (push_i) begin
         r_head <= w_head_inc;
         if (!w_full) r_count <= r_count + CNT_W'(1);
      end else if (pop_i && !w_empty) begin
         r_head  <= r_head - PTR_W'(1);
         r_count <= r_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) r_mem[w_head_inc] <= data_i;
   end

   assign top_o   = r_mem[r_head];
   assign empty_o = w_empty;
   assign full_o  = w_full;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter: IDLE/RUN FSM, stall-deferred redirect
// register and the prioritised next-PC mux, backed by a return-address stack.
module pc_unit #(
   parameter int              PC_W      = 32,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(32'h0000_0100),
   parameter int              INC       = 4,
   parameter int              RAS_DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            start_i,
   input  logic            stall_i,
   input  logic            exc_i,
   input  logic            redirect_i,
   input  logic [PC_W-1:0] redirect_pc_i,
   input  logic            call_i,
   input  logic            ret_i,
   output logic [PC_W-1:0] pc_o,
   output logic            pc_valid_o,
   output logic            redirect_pending_o,
   output logic            ras_empty_o,
   output logic            ras_full_o
);

   import pc_pkg::*;

   pc_state_t       r_state;
   pc_state_t       w_state_nxt;
   logic [PC_W-1:0] r_pc;
   logic [PC_W-1:0] w_pc_nxt;
   logic            r_pend;
   logic            w_pend_nxt;
   logic [PC_W-1:0] r_pend_pc;
   logic [PC_W-1:0] w_pend_pc_nxt;
   logic [PC_W-1:0] w_pc_inc;
   logic [PC_W-1:0] w_ras_top;
   logic            w_ras_empty;
   logic            w_ras_full;
   logic            w_push;
   logic            w_pop;
   pc_src_t         w_src;

   assign w_pc_inc = r_pc + PC_W'(INC);

   always_comb begin
      w_src = SEQ;
      if (exc_i)                      w_src = EXC;
      else if (stall_i)               w_src = HOLD;
      else if (redirect_i)            w_src = REDIR;
      else if (r_pend)                w_src = PEND;
      else if (ret_i && !w_ras_empty) w_src = RET;
   end

   // In IDLE every input but start_i is ignored, so the mux only acts in RUN.
   always_comb begin
      w_state_nxt   = r_state;
      w_pc_nxt      = r_pc;
      w_pend_nxt    = r_pend;
      w_pend_pc_nxt = r_pend_pc;
      w_push        = 1'b0;
      w_pop         = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start_i) w_state_nxt = RUN;
         end
         RUN: begin
            case (w_src)
               EXC: begin
                  w_pc_nxt   = EXC_VEC;
                  w_pend_nxt = 1'b0;
               end
               HOLD: begin
                  if (redirect_i) begin
                     w_pend_nxt    = 1'b1;
                     w_pend_pc_nxt = redirect_pc_i;
                  end
               end
               REDIR: begin
                  w_pc_nxt   = redirect_pc_i;
                  w_pend_nxt = 1'b0;
                  w_push     = call_i;
               end
               PEND: begin
                  w_pc_nxt   = r_pend_pc;
                  w_pend_nxt = 1'b0;
               end
               RET: begin
                  w_pc_nxt = w_ras_top;
                  w_pop    = 1'b1;
               end
               default: w_pc_nxt = w_pc_inc;
            endcase
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state   <= IDLE;
         r_pc      <= RESET_PC;
         r_pend    <= 1'b0;
         r_pend_pc <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_pend    <= w_pend_nxt;
         r_pend_pc <= w_pend_pc_nxt;
      end
   end

   ras_stack #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_push),
      .pop_i   (w_pop),
      .data_i  (w_pc_inc),
      .top_o   (w_ras_top),
      .empty_o (w_ras_empty),
      .full_o  (w_ras_full)
   );

   assign pc_o               = r_pc;
   assign pc_valid_o         = (r_state == RUN);
   assign redirect_pending_o = r_pend;
   assign ras_empty_o        = w_ras_empty;
   assign ras_full_o         = w_ras_full;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: a 32-bit and an 8-bit instance share one stimulus
// stream and are checked against a queue-based behavioural model.
module tb_pc_unit;

   logic        clk_i         = 1'b0;
   logic        rst_i         = 1'b0;
   logic        start_i       = 1'b0;
   logic        stall_i       = 1'b0;
   logic        exc_i         = 1'b0;
   logic        redirect_i    = 1'b0;
   logic        call_i        = 1'b0;
   logic        ret_i         = 1'b0;
   logic [31:0] redirect_pc_i = '0;

   logic [31:0] pc_o;
   logic        pc_valid_o, redirect_pending_o, ras_empty_o, ras_full_o;
   logic [7:0]  pc8_o;
   logic        valid8_o, pend8_o, empty8_o, full8_o;

   always #5 clk_i = ~clk_i;

   pc_unit dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
      .exc_i(exc_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
      .call_i(call_i), .ret_i(ret_i), .pc_o(pc_o), .pc_valid_o(pc_valid_o),
      .redirect_pending_o(redirect_pending_o), .ras_empty_o(ras_empty_o),
      .ras_full_o(ras_full_o)
   );

   pc_unit #(
      .PC_W(8), .RESET_PC(8'h00), .EXC_VEC(8'h40), .INC(4), .RAS_DEPTH(4)
   ) dut8 (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
      .exc_i(exc_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i[7:0]),
      .call_i(call_i), .ret_i(ret_i), .pc_o(pc8_o), .pc_valid_o(valid8_o),
      .redirect_pending_o(pend8_o), .ras_empty_o(empty8_o), .ras_full_o(full8_o)
   );

   // Observed vectors: {pc, valid, pending, empty, full}
   logic [35:0] obs [2];
   assign obs[0] = {pc_o, pc_valid_o, redirect_pending_o, ras_empty_o, ras_full_o};
   assign obs[1] = {24'h0, pc8_o, valid8_o, pend8_o, empty8_o, full8_o};

   // Behavioural model, one copy per instance (0: 32-bit, 1: 8-bit)
   logic [31:0] m_pc      [2];
   bit          m_run     [2];
   bit          m_pend    [2];
   logic [31:0] m_pend_pc [2];
   logic [31:0] m_ras     [2][$];

   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [31:0] mask(int u);
      return (u == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
   endfunction

   function automatic logic [31:0] exc_vec(int u);
      return (u == 0) ? 32'h0000_0100 : 32'h0000_0040;
   endfunction

   function automatic logic [35:0] exp_vec(int u);
      return {m_pc[u], m_run[u], m_pend[u], m_ras[u].size() == 0, m_ras[u].size() == 4};
   endfunction

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         m_pc[u] = '0; m_run[u] = 0; m_pend[u] = 0; m_pend_pc[u] = '0;
         m_ras[u].delete();
      end
   endfunction

   function automatic void model_step(int u);
      logic [31:0] nxt;
      nxt = (m_pc[u] + 32'd4) & mask(u);
      if (!m_run[u]) begin
         if (start_i) m_run[u] = 1;
      end else if (exc_i) begin
         m_pc[u] = exc_vec(u); m_pend[u] = 0;
      end else if (stall_i) begin
         if (redirect_i) begin m_pend[u] = 1; m_pend_pc[u] = redirect_pc_i & mask(u); end
      end else if (redirect_i) begin
         if (call_i) begin
            if (m_ras[u].size() == 4) void'(m_ras[u].pop_front());
            m_ras[u].push_back(nxt);
         end
         m_pc[u] = redirect_pc_i & mask(u); m_pend[u] = 0;
      end else if (m_pend[u]) begin
         m_pc[u] = m_pend_pc[u]; m_pend[u] = 0;
      end else if (ret_i && m_ras[u].size() > 0) begin
         m_pc[u] = m_ras[u].pop_back();
      end else begin
         m_pc[u] = nxt;
      end
   endfunction

   task automatic step();
      @(posedge clk_i);
      model_step(0);
      model_step(1);
      #1;
   endtask

   task automatic clear_inputs();
      start_i = 0; stall_i = 0; exc_i = 0; redirect_i = 0; call_i = 0; ret_i = 0;
   endtask

   task automatic test_reset();
      model_reset();
      #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (obs[u] !== exp_vec(u)) begin
            n_fail++; $display("FAIL reset_state u%0d: got %h want %h", u, obs[u], exp_vec(u));
         end
      end
      n_checks++;
      if (pc_o !== 32'h0 || pc_valid_o !== 1'b0 || ras_empty_o !== 1'b1) begin
         n_fail++; $display("FAIL reset_const: pc %h valid %b empty %b want 0/0/1", pc_o, pc_valid_o, ras_empty_o);
      end
   endtask

   task automatic test_start();
      redirect_i = 1; redirect_pc_i = 32'h44; stall_i = 1;
      step();
      step();
      clear_inputs();
      rst_i = 1;
      step();
      n_checks++;
      if (obs[0] !== exp_vec(0) || pc_valid_o !== 1'b0) begin
         n_fail++; $display("FAIL idle_hold: got %h want %h", obs[0], exp_vec(0));
      end
      start_i = 1;
      step();
      start_i = 0;
      n_checks++;
      if (pc_o !== 32'h0 || pc_valid_o !== 1'b1) begin
         n_fail++; $display("FAIL start_valid: pc %h valid %b want 0/1", pc_o, pc_valid_o);
      end
      for (int i = 1; i <= 3; i++) begin
         step();
         n_checks++;
         if (pc_o !== 32'(4 * i) || obs[1] !== exp_vec(1)) begin
            n_fail++; $display("FAIL start_inc%0d: pc %h want %h", i, pc_o, 32'(4 * i));
         end
      end
   endtask

   task automatic test_stalled_redirect();
      redirect_i = 1; redirect_pc_i = 32'h20;
      step();
      stall_i = 1; redirect_pc_i = 32'h80;
      step();
      redirect_pc_i = 32'h90;
      step();
      redirect_i = 0;
      step();
      n_checks++;
      if (pc_o !== 32'h20 || redirect_pending_o !== 1'b1 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL stall_hold: pc %h pend %b want 20/1", pc_o, redirect_pending_o);
      end
      stall_i = 0;
      step();
      n_checks++;
      if (pc_o !== 32'h90 || redirect_pending_o !== 1'b0 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL pend_apply: pc %h pend %b want 90/0", pc_o, redirect_pending_o);
      end
      // a fresh redirect on the first unstalled cycle beats the pending one
      stall_i = 1; redirect_i = 1; redirect_pc_i = 32'hA0;
      step();
      stall_i = 0; redirect_pc_i = 32'hB0;
      step();
      redirect_i = 0;
      n_checks++;
      if (pc_o !== 32'hB0 || redirect_pending_o !== 1'b0) begin
         n_fail++; $display("FAIL pend_superseded: pc %h pend %b want b0/0", pc_o, redirect_pending_o);
      end
   endtask

   task automatic test_exception();
      stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h50;
      step();
      exc_i = 1; redirect_pc_i = 32'h60;
      step();
      clear_inputs();
      n_checks++;
      if (pc_o !== 32'h100 || pc8_o !== 8'h40 || redirect_pending_o !== 1'b0) begin
         n_fail++; $display("FAIL exc_priority: pc %h pc8 %h pend %b want 100/40/0", pc_o, pc8_o, redirect_pending_o);
      end
   endtask

   task automatic test_ras();
      redirect_i = 1; redirect_pc_i = 32'h10;
      step();
      call_i = 1; redirect_pc_i = 32'h200;
      step();
      clear_inputs();
      n_checks++;
      if (pc_o !== 32'h200 || ras_empty_o !== 1'b0) begin
         n_fail++; $display("FAIL ras_call: pc %h empty %b want 200/0", pc_o, ras_empty_o);
      end
      ret_i = 1;
      step();
      n_checks++;
      if (pc_o !== 32'h14 || ras_empty_o !== 1'b1 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL ras_ret: pc %h empty %b want 14/1", pc_o, ras_empty_o);
      end
      step();
      ret_i = 0;
      n_checks++;
      if (pc_o !== 32'h18 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL ras_ret_empty: pc %h want 18", pc_o);
      end
   endtask

   task automatic test_ras_overflow();
      redirect_i = 1; redirect_pc_i = 32'h0;
      step();
      call_i = 1;
      for (int k = 1; k <= 5; k++) begin
         redirect_pc_i = 32'(k * 32'h100);
         step();
      end
      clear_inputs();
      n_checks++;
      if (ras_full_o !== 1'b1 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL ras_full: full %b want 1", ras_full_o);
      end
      ret_i = 1;
      for (int k = 0; k < 4; k++) begin
         step();
         n_checks++;
         if (pc_o !== 32'(32'h404 - k * 32'h100) || obs[1] !== exp_vec(1)) begin
            n_fail++; $display("FAIL ras_pop%0d: pc %h want %h", k, pc_o, 32'(32'h404 - k * 32'h100));
         end
      end
      n_checks++;
      if (ras_empty_o !== 1'b1 || ras_full_o !== 1'b0) begin
         n_fail++; $display("FAIL ras_drained: empty %b full %b want 1/0", ras_empty_o, ras_full_o);
      end
      step();
      ret_i = 0;
      n_checks++;
      if (pc_o !== 32'h108) begin
         n_fail++; $display("FAIL ras_fifth_ret: pc %h want 108", pc_o);
      end
   endtask

   task automatic test_wrap();
      redirect_i = 1; redirect_pc_i = 32'hFC;
      step();
      redirect_i = 0;
      step();
      n_checks++;
      if (pc8_o !== 8'h00 || pc_o !== 32'h100) begin
         n_fail++; $display("FAIL wrap: pc8 %h pc %h want 00/100", pc8_o, pc_o);
      end
      redirect_i = 1; redirect_pc_i = 32'hFFFF_FFFC;
      step();
      redirect_i = 0;
      step();
      n_checks++;
      if (pc_o !== 32'h0 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL wrap32: pc %h want 0", pc_o);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         exc_i         = ($urandom_range(0, 19) == 0);
         stall_i       = ($urandom_range(0, 3) == 0);
         redirect_i    = ($urandom_range(0, 3) == 0);
         call_i        = ($urandom_range(0, 1) == 0);
         ret_i         = ($urandom_range(0, 2) == 0);
         redirect_pc_i = $urandom();
         step();
         for (int u = 0; u < 2; u++) begin
            n_checks++;
            if (obs[u] !== exp_vec(u)) begin
               n_fail++; $display("FAIL random c%0d u%0d: got %h want %h", i, u, obs[u], exp_vec(u));
            end
         end
      end
      clear_inputs();
   endtask

   task automatic test_reset_mid_stall();
      stall_i = 1; redirect_i = 1; redirect_pc_i = 32'h70; call_i = 1;
      step();
      n_checks++;
      if (redirect_pending_o !== 1'b1 || pend8_o !== 1'b1) begin
         n_fail++; $display("FAIL pre_reset_pend: pend %b pend8 %b want 1/1", redirect_pending_o, pend8_o);
      end
      #2;
      rst_i = 0;
      model_reset();
      #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (obs[u] !== exp_vec(u)) begin
            n_fail++; $display("FAIL async_reset u%0d: got %h want %h", u, obs[u], exp_vec(u));
         end
      end
      clear_inputs();
      rst_i = 1;
      step();
      n_checks++;
      if (pc_valid_o !== 1'b0 || pc_o !== 32'h0 || obs[1] !== exp_vec(1)) begin
         n_fail++; $display("FAIL post_reset_idle: pc %h valid %b want 0/0", pc_o, pc_valid_o);
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_stalled_redirect();
      test_exception();
      test_ras();
      test_ras_overflow();
      test_wrap();
      test_random();
      test_reset_mid_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
